// File: rtl/label_resolver_pkg.sv
// Shared definitions for the label resolver: default widths and the resolver FSM encoding.
package label_resolver_pkg;

    localparam int WORD_SIZE     = 8;
    localparam int MAX_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        RES_IDLE   = 2'd0,
        RES_LOOKUP = 2'd1,
        RES_CHECK  = 2'd2,
        RES_EMIT   = 2'd3
    } res_state_e;

endpackage

// File: rtl/label_resolver_cache.sv
// One-entry key/value result cache; a write wins over a flush arriving in the same cycle.
module label_cache
    import label_resolver_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_key,
    input  logic [WIDTH-1:0] wr_val,
    input  logic [WIDTH-1:0] lookup_key,
    output logic             hit,
    output logic [WIDTH-1:0] val
);

    logic             valid;
    logic [WIDTH-1:0] key;

    // NOTE: key/val are reset along with valid so nothing downstream ever sees X after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            key   <= '0;
            val   <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            key   <= wr_key;
            val   <= wr_val;
        end else if (flush) begin
            valid <= 1'b0;
        end
    end

    // A flush coinciding with a lookup forces a miss.
    assign hit = valid && !flush && (key == lookup_key);

endmodule

// File: rtl/label_resolver.sv
// Second-pass label resolver: follows max->min merge chains in an external table to the root label.
module label_resolver
    import label_resolver_pkg::*;
#(
    parameter int WIDTH     = WORD_SIZE,
    parameter int MAX_DEPTH = MAX_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_label,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_label,
    output logic             tbl_ren,
    output logic [WIDTH-1:0] tbl_addr,
    input  logic [WIDTH-1:0] tbl_data,
    output logic             err,
    output logic             busy
);

    localparam int HOPS_W = $clog2(MAX_DEPTH + 1);

    res_state_e        state;
    logic [WIDTH-1:0]  cur;
    logic [WIDTH-1:0]  key;
    logic [HOPS_W-1:0] hops;
    logic [WIDTH-1:0]  cache_val;
    logic [WIDTH-1:0]  result;
    logic              cache_hit;
    logic              cache_wr;
    logic              is_root;
    logic              at_limit;

    assign in_ready = (state == RES_IDLE);
    assign busy     = (state != RES_IDLE);

    // Merges only ever point downward, so anything else terminates the chain.
    always_comb begin
        is_root  = (tbl_data == cur) || (tbl_data == '0) || (tbl_data > cur);
        at_limit = (hops == HOPS_W'(MAX_DEPTH));
        result   = is_root ? cur : tbl_data;
        cache_wr = (state == RES_CHECK) && (is_root || at_limit);
    end

    label_cache #(.WIDTH(WIDTH)) u_cache (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .wr_en      (cache_wr),
        .wr_key     (key),
        .wr_val     (result),
        .lookup_key (in_label),
        .hit        (cache_hit),
        .val        (cache_val)
    );

    // NOTE: state and outputs update with <= so every branch reads the pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RES_IDLE;
            cur       <= '0;
            key       <= '0;
            hops      <= '0;
            out_valid <= 1'b0;
            out_label <= '0;
            tbl_ren   <= 1'b0;
            tbl_addr  <= '0;
            err       <= 1'b0;
        end else begin
            // A depth-limit hit later in this block overrides the clear.
            if (flush) err <= 1'b0;

            case (state)
                RES_IDLE: begin
                    if (in_valid) begin
                        if (in_label == '0) begin
                            out_label <= '0;
                            out_valid <= 1'b1;
                            state     <= RES_EMIT;
                        end else if (cache_hit) begin
                            out_label <= cache_val;
                            out_valid <= 1'b1;
                            state     <= RES_EMIT;
                        end else begin
                            cur      <= in_label;
                            key      <= in_label;
                            hops     <= '0;
                            tbl_ren  <= 1'b1;
                            tbl_addr <= in_label;
                            state    <= RES_LOOKUP;
                        end
                    end
                end
                RES_LOOKUP: begin
                    tbl_ren <= 1'b0;
                    hops    <= hops + HOPS_W'(1);
                    state   <= RES_CHECK;
                end
                RES_CHECK: begin
                    if (is_root || at_limit) begin
                        out_label <= result;
                        out_valid <= 1'b1;
                        state     <= RES_EMIT;
                        if (!is_root) err <= 1'b1;
                    end else begin
                        cur      <= tbl_data;
                        tbl_ren  <= 1'b1;
                        tbl_addr <= tbl_data;
                        state    <= RES_LOOKUP;
                    end
                end
                RES_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= RES_IDLE;
                    end
                end
                default: state <= RES_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_label_resolver.sv
// Scoreboard bench for label_resolver: instance a uses MAX_DEPTH=8, instance b uses MAX_DEPTH=2.
module tb_label_resolver;

    typedef struct {
        logic [7:0] label;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    int         cyc = 0;

    logic       flush_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b1;
    logic [7:0] in_label_a = '0;
    logic       in_ready_a, out_valid_a, tbl_ren_a, err_a, busy_a;
    logic [7:0] out_label_a, tbl_addr_a, tbl_data_a;

    logic       flush_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b1;
    logic [7:0] in_label_b = '0;
    logic       in_ready_b, out_valid_b, tbl_ren_b, err_b, busy_b;
    logic [7:0] out_label_b, tbl_addr_b, tbl_data_b;

    logic [7:0] mem [256];
    exp_t       q_a[$], q_b[$];
    logic [7:0] addr_a[$], addr_b[$];
    int         reads_a = 0, reads_b = 0, hs_a = 0, hs_b = 0;
    int         n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    label_resolver #(.WIDTH(8), .MAX_DEPTH(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_label(in_label_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_label(out_label_a),
        .tbl_ren(tbl_ren_a), .tbl_addr(tbl_addr_a), .tbl_data(tbl_data_a),
        .err(err_a), .busy(busy_a)
    );

    label_resolver #(.WIDTH(8), .MAX_DEPTH(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_label(in_label_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_label(out_label_b),
        .tbl_ren(tbl_ren_b), .tbl_addr(tbl_addr_b), .tbl_data(tbl_data_b),
        .err(err_b), .busy(busy_b)
    );

    // Merge table {1->1, 2->1, 3->2, 4->3}; every other entry is 0 (a root).
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        mem[1] = 8'd1; mem[2] = 8'd1; mem[3] = 8'd2; mem[4] = 8'd3;
    end

    always @(posedge clk) begin
        if (tbl_ren_a) tbl_data_a <= mem[tbl_addr_a];
        if (tbl_ren_b) tbl_data_b <= mem[tbl_addr_b];
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] pack_q(input logic [7:0] q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = (v << 8) | 32'(q[i]);
        return v;
    endfunction

    // Monitor: first-valid cycle is the latency point; a handshake pops and compares.
    int   first_a = 0, first_b = 0;
    logic prev_v_a = 1'b0, prev_v_b = 1'b0;
    always begin
        exp_t e;
        @(negedge clk); #1;
        if (tbl_ren_a) begin reads_a++; addr_a.push_back(tbl_addr_a); end
        if (tbl_ren_b) begin reads_b++; addr_b.push_back(tbl_addr_b); end
        if (out_valid_a && !prev_v_a) first_a = cyc;
        if (out_valid_b && !prev_v_b) first_b = cyc;
        prev_v_a = out_valid_a;
        prev_v_b = out_valid_b;
        if (out_valid_a && out_ready_a) begin
            hs_a++;
            if (q_a.size() == 0) check("unexpected_output_a", 1, 0);
            else begin
                e = q_a.pop_front();
                check("label_a", out_label_a, e.label);
                check("latency_a", first_a, e.cyc);
            end
        end
        if (out_valid_b && out_ready_b) begin
            hs_b++;
            if (q_b.size() == 0) check("unexpected_output_b", 1, 0);
            else begin
                e = q_b.pop_front();
                check("label_b", out_label_b, e.label);
                check("latency_b", first_b, e.cyc);
            end
        end
    end

    task automatic issue_a(input logic [7:0] label, input logic [7:0] exp, input int lat, input logic fl);
        int n = 0;
        @(negedge clk);
        while (!in_ready_a && n < 50) begin @(negedge clk); n++; end
        in_valid_a = 1'b1; in_label_a = label; flush_a = fl;
        q_a.push_back('{label: exp, cyc: cyc + lat});
        @(negedge clk);
        in_valid_a = 1'b0; flush_a = 1'b0;
    endtask

    task automatic issue_b(input logic [7:0] label, input logic [7:0] exp, input int lat);
        int n = 0;
        @(negedge clk);
        while (!in_ready_b && n < 50) begin @(negedge clk); n++; end
        in_valid_b = 1'b1; in_label_b = label;
        q_b.push_back('{label: exp, cyc: cyc + lat});
        @(negedge clk);
        in_valid_b = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 60) begin @(negedge clk); n++; end
        if (n >= 60) check({name, "_drain_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic check_idle_reset(input string name);
        check({name, "_in_ready"}, in_ready_a, 1);
        check({name, "_out_valid"}, out_valid_a, 0);
        check({name, "_out_label"}, out_label_a, 0);
        check({name, "_tbl_ren"}, tbl_ren_a, 0);
        check({name, "_tbl_addr"}, tbl_addr_a, 0);
        check({name, "_err"}, err_a, 0);
        check({name, "_busy"}, busy_a, 0);
    endtask

    initial begin
        int r0, hs0, n;
        #200000;
        $display("FAIL global_timeout: got %0d expected 0", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int r0, hs0, n;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_idle_reset("reset");
        check("reset_err_b", err_b, 0);
        reset_n = 1'b1;

        // Three-hop chain 3->2->1.
        addr_a.delete(); r0 = reads_a;
        issue_a(8'd3, 8'd1, 7, 1'b0);
        drain("chain");
        check("chain_reads", reads_a - r0, 3);
        check("chain_addrs", pack_q(addr_a), 32'h00030201);
        check("chain_err", err_a, 0);

        // Background label: no table access.
        r0 = reads_a;
        issue_a(8'd0, 8'd0, 1, 1'b0);
        drain("bg");
        check("bg_reads", reads_a - r0, 0);

        // Cache hit on a repeated label.
        r0 = reads_a;
        issue_a(8'd3, 8'd1, 1, 1'b0);
        drain("hit");
        check("hit_reads", reads_a - r0, 0);

        // Flush, then the same label takes the full path.
        @(negedge clk); flush_a = 1'b1;
        @(negedge clk); flush_a = 1'b0;
        r0 = reads_a;
        issue_a(8'd3, 8'd1, 7, 1'b0);
        drain("flushed");
        check("flushed_reads", reads_a - r0, 3);

        // Backpressure: root label 5 held while out_ready is low.
        out_ready_a = 1'b0;
        issue_a(8'd5, 8'd5, 3, 1'b0);
        n = 0;
        while (!out_valid_a && n < 20) begin @(negedge clk); n++; end
        repeat (5) begin
            #1;
            check("bp_out_valid", out_valid_a, 1);
            check("bp_out_label", out_label_a, 5);
            check("bp_in_ready", in_ready_a, 0);
            @(negedge clk);
        end
        hs0 = hs_a;
        out_ready_a = 1'b1;
        @(negedge clk); #1;
        check("bp_single_handshake", hs_a - hs0, 1);
        check("bp_idle_in_ready", in_ready_a, 1);
        check("bp_idle_busy", busy_a, 0);
        check("bp_idle_out_valid", out_valid_a, 0);

        // Flush in the accept cycle turns a would-be hit into a miss.
        r0 = reads_a;
        issue_a(8'd5, 8'd5, 3, 1'b1);
        drain("flush_accept");
        check("flush_accept_reads", reads_a - r0, 1);

        // Leave label 3 cached ahead of the reset test.
        issue_a(8'd3, 8'd1, 7, 1'b0);
        drain("precache");

        // Depth limit on instance b: 4->3->2 stops after two reads at 2.
        addr_b.delete(); r0 = reads_b;
        issue_b(8'd4, 8'd2, 5);
        drain("depth");
        check("depth_reads", reads_b - r0, 2);
        check("depth_addrs", pack_q(addr_b), 32'h00000403);
        check("depth_err", err_b, 1);
        repeat (3) @(negedge clk);
        #1 check("depth_err_sticky", err_b, 1);
        @(negedge clk); flush_b = 1'b1;
        @(negedge clk); flush_b = 1'b0;
        #1 check("depth_err_cleared", err_b, 0);

        // Flush in the same cycle as the err-setting CHECK: set wins.
        issue_b(8'd4, 8'd2, 5);
        repeat (3) @(negedge clk);
        flush_b = 1'b1;
        @(negedge clk); flush_b = 1'b0;
        drain("set_prio");
        check("set_prio_err", err_b, 1);

        // Reset during CHECK aborts with no output; cache is lost.
        @(negedge clk);
        in_valid_a = 1'b1; in_label_a = 8'd4;
        @(negedge clk); in_valid_a = 1'b0;
        @(negedge clk); #1;
        check("pre_reset_busy", busy_a, 1);
        reset_n = 1'b0;
        #1 check_idle_reset("midreset");
        check("midreset_err_b", err_b, 0);
        @(negedge clk); #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_no_output", out_valid_a, 0);
        r0 = reads_a;
        issue_a(8'd3, 8'd1, 7, 1'b0);
        drain("post_reset");
        check("post_reset_reads", reads_a - r0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
